fifo_wr_ingress: RTL and testbench

Write-side ingress stage placed directly upstream of the async FIFO write-pointer/full logic. It accepts producer beats on a valid/ready handshake and holds them in a 2-entry skid buffer. It drives winc and wdata (the memory write enable and data) only while wfull is low. It also keeps write, stall and drop statistics for debug.

---
 rtl/fifo_wr_ingress.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_ingress.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress
// Write-side ingress stage in front of the async FIFO write-pointer/full logic.
// Producer beats arrive on a valid/ready handshake and go into a 2-entry skid
// buffer (head + skid). The head is written into the FIFO whenever wfull is low.
// The block also keeps debug counters for writes, stall cycles and dropped beats.
//
// Ports:
//   wclk       write-domain clock
//   wrst_n     asynchronous active-low reset
//   in_valid   producer beat valid
//   in_ready   ingress can take a beat
//   in_data    producer data
//   wfull      FIFO full, from the write-pointer/full block
//   winc       write strobe / memory write enable (head_valid & ~wfull)
//   wdata      write data to FIFO memory (buffer head)
//   buf_lvl    skid buffer occupancy, 0..2
//   cnt_clr    synchronous clear of all counters
//   wr_cnt     writes issued (wrapping)
//   stall_cnt  cycles with data held while wfull is high (saturating)
//   drop_cnt   beats dropped in DROP_ON_FULL mode (saturating)
module fifo_wr_ingress #(
   parameter int unsigned DSIZE        = 8,
   parameter int unsigned CNT_W        = 16,
   parameter bit          DROP_ON_FULL = 1'b0
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DSIZE-1:0] in_data,
   input  logic             wfull,
   output logic             winc,
   output logic [DSIZE-1:0] wdata,
   output logic [1:0]       buf_lvl,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [DSIZE-1:0] head;
   logic [DSIZE-1:0] head_nxt;
   logic [DSIZE-1:0] skid;
   logic [DSIZE-1:0] skid_nxt;
   logic             ready_q;
   logic             head_valid;
   logic             pop;
   logic             accept;
   logic             drop;

   assign head_valid = (state != EMPTY);
   // wfull may rise asynchronously; the pointer block samples the same wfull
   // at the edge, so winc is only meaningful there and never high with wfull.
   assign winc       = head_valid & ~wfull;
   assign pop        = winc;
   assign in_ready   = DROP_ON_FULL ? 1'b1 : ready_q;
   assign accept     = in_valid & in_ready;
   // Only reachable in drop mode: backpressure mode keeps in_ready low in TWO.
   assign drop       = DROP_ON_FULL && (state == TWO) && in_valid && !pop;
   assign wdata      = head;
   assign buf_lvl    = state;

   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      skid_nxt  = skid;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               head_nxt  = in_data;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_nxt = TWO;
               skid_nxt  = in_data;
            end else if (pop && !accept) begin
               state_nxt = EMPTY;
            end else if (pop && accept) begin
               head_nxt  = in_data;
            end
         end
         TWO: begin
            if (pop) begin
               head_nxt = skid;
               if (accept) begin
                  skid_nxt = in_data;
               end else begin
                  state_nxt = ONE;
               end
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state   <= EMPTY;
         head    <= '0;
         skid    <= '0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         head    <= head_nxt;
         skid    <= skid_nxt;
         ready_q <= (state_nxt != TWO);
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wr_cnt    <= '0;
         stall_cnt <= '0;
         drop_cnt  <= '0;
      end else if (cnt_clr) begin
         wr_cnt    <= '0;
         stall_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (pop) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
         end
         if (head_valid && wfull && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Testbench for fifo_wr_ingress: three instances (backpressure, drop-on-full,
// 4-bit counters) share one stimulus stream and are compared every cycle
// against a queue-based reference model.
module tb_fifo_wr_ingress;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       wfull;
   logic       cnt_clr;

   logic        in_ready0, in_ready1, in_ready2;
   logic        winc0, winc1, winc2;
   logic [7:0]  wdata0, wdata1, wdata2;
   logic [1:0]  buf_lvl0, buf_lvl1, buf_lvl2;
   logic [15:0] wr_cnt0, wr_cnt1, stall_cnt0, stall_cnt1, drop_cnt0, drop_cnt1;
   logic [3:0]  wr_cnt2, stall_cnt2, drop_cnt2;

   always #5 wclk = ~wclk;

   fifo_wr_ingress #(.DSIZE(8), .CNT_W(16), .DROP_ON_FULL(1'b0)) u_bp (
      .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .wfull(wfull), .winc(winc0), .wdata(wdata0),
      .buf_lvl(buf_lvl0), .cnt_clr(cnt_clr), .wr_cnt(wr_cnt0),
      .stall_cnt(stall_cnt0), .drop_cnt(drop_cnt0));

   fifo_wr_ingress #(.DSIZE(8), .CNT_W(16), .DROP_ON_FULL(1'b1)) u_drop (
      .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .wfull(wfull), .winc(winc1), .wdata(wdata1),
      .buf_lvl(buf_lvl1), .cnt_clr(cnt_clr), .wr_cnt(wr_cnt1),
      .stall_cnt(stall_cnt1), .drop_cnt(drop_cnt1));

   fifo_wr_ingress #(.DSIZE(8), .CNT_W(4), .DROP_ON_FULL(1'b0)) u_sat (
      .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .wfull(wfull), .winc(winc2), .wdata(wdata2),
      .buf_lvl(buf_lvl2), .cnt_clr(cnt_clr), .wr_cnt(wr_cnt2),
      .stall_cnt(stall_cnt2), .drop_cnt(drop_cnt2));

   int checks   = 0;
   int failures = 0;

   // Reference model: per instance, a queue of buffered beats in arrival order.
   logic [7:0]  mq [3][$];
   bit          mrdy [3];
   int unsigned mwr  [3];
   int unsigned mst  [3];
   int unsigned mdr  [3];
   bit          mdrop [3] = '{1'b0, 1'b1, 1'b0};
   int unsigned mmask [3] = '{32'hFFFF, 32'hFFFF, 32'hF};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         mrdy[i] = 1'b1;
         mwr[i]  = 0;
         mst[i]  = 0;
         mdr[i]  = 0;
      end
   endtask

   // Apply one clock edge to the model using the currently held inputs.
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int  lvl;
         bit  pop, rdy, acc, dropped;
         lvl     = mq[i].size();
         pop     = (lvl > 0) && !wfull;
         rdy     = mdrop[i] ? 1'b1 : mrdy[i];
         acc     = in_valid && rdy;
         dropped = acc && (lvl == 2) && !pop;
         if (cnt_clr) begin
            mwr[i] = 0;
            mst[i] = 0;
            mdr[i] = 0;
         end else begin
            if (pop) mwr[i] = (mwr[i] + 1) & mmask[i];
            if ((lvl > 0) && wfull && (mst[i] != mmask[i])) mst[i] = mst[i] + 1;
            if (dropped && (mdr[i] != mmask[i])) mdr[i] = mdr[i] + 1;
         end
         if (pop) void'(mq[i].pop_front());
         if (acc && !dropped) mq[i].push_back(in_data);
         mrdy[i] = (mq[i].size() != 2);
      end
   endtask

   task automatic check_inst(input int i);
      logic [31:0] o_rdy, o_winc, o_wdata, o_lvl, o_wr, o_st, o_dr;
      int lvl;
      case (i)
         0: begin
            o_rdy = in_ready0; o_winc = winc0; o_wdata = wdata0; o_lvl = buf_lvl0;
            o_wr = wr_cnt0; o_st = stall_cnt0; o_dr = drop_cnt0;
         end
         1: begin
            o_rdy = in_ready1; o_winc = winc1; o_wdata = wdata1; o_lvl = buf_lvl1;
            o_wr = wr_cnt1; o_st = stall_cnt1; o_dr = drop_cnt1;
         end
         default: begin
            o_rdy = in_ready2; o_winc = winc2; o_wdata = wdata2; o_lvl = buf_lvl2;
            o_wr = wr_cnt2; o_st = stall_cnt2; o_dr = drop_cnt2;
         end
      endcase
      lvl = mq[i].size();
      chk($sformatf("in_ready[%0d]", i), o_rdy, mdrop[i] ? 32'd1 : 32'(mrdy[i]));
      chk($sformatf("winc[%0d]", i), o_winc, 32'((lvl > 0) && !wfull));
      chk($sformatf("winc_vs_wfull[%0d]", i), o_winc & 32'(wfull), 32'd0);
      chk($sformatf("buf_lvl[%0d]", i), o_lvl, 32'(lvl));
      if (lvl > 0) chk($sformatf("wdata[%0d]", i), o_wdata, 32'(mq[i][0]));
      chk($sformatf("wr_cnt[%0d]", i), o_wr, mwr[i]);
      chk($sformatf("stall_cnt[%0d]", i), o_st, mst[i]);
      chk($sformatf("drop_cnt[%0d]", i), o_dr, mdr[i]);
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) check_inst(i);
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit c);
      @(negedge wclk);
      in_valid = v;
      in_data  = d;
      wfull    = f;
      cnt_clr  = c;
      #1;
      check_all();
      @(posedge wclk);
      model_step();
   endtask

   initial begin
      // Reset state
      wrst_n   = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      wfull    = 1'b0;
      cnt_clr  = 1'b0;
      model_reset();
      @(negedge wclk);
      #1;
      check_all();
      chk("rst_wdata0", 32'(wdata0), 32'd0);
      chk("rst_wdata1", 32'(wdata1), 32'd0);
      chk("rst_in_ready0", 32'(in_ready0), 32'd1);
      wrst_n = 1'b1;
      @(posedge wclk);
      model_step();

      // Free-flowing stream of 20 beats
      for (int k = 0; k < 20; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      chk("stream_wr_cnt0", 32'(wr_cnt0), 32'd20);
      chk("stream_wr_cnt1", 32'(wr_cnt1), 32'd20);
      chk("stream_wr_cnt2_wrap", 32'(wr_cnt2), 32'd4);

      // Stream with a 5-cycle wfull window
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 15; k++) cycle(1'b1, 8'(8'h20 + k), (k >= 5) && (k < 10), 1'b0);
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      chk("stall_cnt0_5", 32'(stall_cnt0), 32'd5);
      chk("stall_cnt1_5", 32'(stall_cnt1), 32'd5);
      chk("stall_cnt2_5", 32'(stall_cnt2), 32'd5);

      // Reset with the buffer full and wfull low
      cycle(1'b1, 8'h40, 1'b1, 1'b0);
      cycle(1'b1, 8'h41, 1'b1, 1'b0);
      cycle(1'b1, 8'h42, 1'b1, 1'b0);
      #2;
      wfull    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_all();
      chk("pre_rst_lvl0", 32'(buf_lvl0), 32'd2);
      wrst_n = 1'b0;
      #1;
      chk("mid_rst_winc0", 32'(winc0), 32'd0);
      chk("mid_rst_lvl0", 32'(buf_lvl0), 32'd0);
      chk("mid_rst_winc1", 32'(winc1), 32'd0);
      chk("mid_rst_lvl1", 32'(buf_lvl1), 32'd0);
      model_reset();
      check_all();
      wrst_n = 1'b1;
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      #2;
      chk("post_rst_wdata0", 32'(wdata0), 32'hA5);
      chk("post_rst_winc0", 32'(winc0), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // stall_cnt saturation on the 4-bit instance, then clear with a pop
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h60, 1'b1, 1'b0);
      repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      #2;
      chk("stall_cnt2_sat", 32'(stall_cnt2), 32'hF);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      #2;
      chk("clr_pop_wr_cnt0", 32'(wr_cnt0), 32'd0);
      chk("clr_pop_wr_cnt2", 32'(wr_cnt2), 32'd0);
      chk("clr_pop_lvl0", 32'(buf_lvl0), 32'd0);

      // wfull toggling every cycle with random valid/data
      for (int k = 0; k < 1000; k++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'(k % 2),
               ($urandom_range(0, 63) == 0));
      end
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      chk("drain_lvl0", 32'(buf_lvl0), 32'd0);
      chk("drain_lvl1", 32'(buf_lvl1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
